// File: rtl/drr_rank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : drr_rank_arbiter_if
// Description : Requester, rank-calculator and control-plane signal bundle
//               for drr_rank_arbiter. The master side is the requesters,
//               calculator and control plane; the slave side is the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface drr_rank_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_DATA_WIDTH  = 24,
  parameter int RESULT_WIDTH    = 32,
  parameter int STALL_CNT_WIDTH = 16
);
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*REQ_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              calc_in_valid;
  logic [REQ_DATA_WIDTH-1:0]         calc_in_data;
  logic                              calc_out_valid;
  logic [RESULT_WIDTH-1:0]           calc_out_data;
  logic [NUM_REQ-1:0]                rsp_valid;
  logic [RESULT_WIDTH-1:0]           rsp_data;
  logic                              cfg_pause_req;
  logic                              cfg_pause_ack;
  logic [STALL_CNT_WIDTH-1:0]        stall_cnt;
  logic                              err_sticky;

  modport master (
    output req_valid, req_data, calc_out_valid, calc_out_data, cfg_pause_req,
    input  req_ready, calc_in_valid, calc_in_data, rsp_valid, rsp_data,
           cfg_pause_ack, stall_cnt, err_sticky
  );

  modport slave (
    input  req_valid, req_data, calc_out_valid, calc_out_data, cfg_pause_req,
    output req_ready, calc_in_valid, calc_in_data, rsp_valid, rsp_data,
           cfg_pause_ack, stall_cnt, err_sticky
  );
endinterface
`default_nettype wire

// File: rtl/drr_rank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : drr_rank_arbiter
// Description : Round-robin arbiter feeding a fixed-latency rank calculator.
//               Issues at most one request every two cycles, tracks in-flight
//               requests with a tag pipeline, routes results back one-hot,
//               supports a drain/pause handshake for weight reconfiguration,
//               counts stall cycles and flags response/tag mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module drr_rank_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int REQ_DATA_WIDTH  = 24,
  parameter int RESULT_WIDTH    = 32,
  parameter int CALC_LATENCY    = 2,
  parameter int STALL_CNT_WIDTH = 16
) (
  input logic               clk_dp,
  input logic               rst,
  drr_rank_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GAP    = 2'd1,
    S_DRAIN  = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [PTR_W-1:0]           r_ptr;

  logic                       r_calc_in_valid;
  logic [REQ_DATA_WIDTH-1:0]  r_calc_in_data;
  logic [PTR_W-1:0]           r_issue_idx;

  logic [CALC_LATENCY-1:0]    r_tag_v;
  logic [PTR_W-1:0]           r_tag_idx [CALC_LATENCY];

  logic [NUM_REQ-1:0]         r_rsp_valid;
  logic [RESULT_WIDTH-1:0]    r_rsp_data;
  logic [STALL_CNT_WIDTH-1:0] r_stall_cnt;
  logic                       r_err_sticky;

  logic [PTR_W-1:0]           w_cand [NUM_REQ];
  logic                       w_found;
  logic [PTR_W-1:0]           w_grant_idx;
  logic                       w_grant_en;
  logic                       w_grant;
  logic [NUM_REQ-1:0]         w_ready;
  logic                       w_tag_out_v;
  logic [PTR_W-1:0]           w_tag_out_idx;
  logic                       w_hit;
  logic                       w_mismatch;
  logic                       w_drained;
  logic                       w_stall_inc;

  // Search order: candidate k is the requester k positions above the pointer.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
    assign w_cand[k] = PTR_W'((32'(r_ptr) + 32'(k)) % 32'(NUM_REQ));
  end

  // Pick the first valid requester in round-robin order.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[w_cand[k]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_cand[k];
      end
    end
  end

  // Grants only from IDLE with no pause request and never while in reset.
  assign w_grant_en = rst && (r_state == S_IDLE) && !bus.cfg_pause_req;
  assign w_grant    = w_grant_en && w_found;
  assign w_ready    = w_grant ? (NUM_REQ'(1) << w_grant_idx) : '0;

  assign w_tag_out_v   = r_tag_v[CALC_LATENCY-1];
  assign w_tag_out_idx = r_tag_idx[CALC_LATENCY-1];
  assign w_hit         = w_tag_out_v && bus.calc_out_valid;
  assign w_mismatch    = w_tag_out_v ^ bus.calc_out_valid;
  assign w_drained     = !r_calc_in_valid && (r_tag_v == '0);
  assign w_stall_inc   = (|bus.req_valid) && !w_grant;

  // Next-state logic for the issue/pause controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.cfg_pause_req) w_state_nxt = S_DRAIN;
        else if (w_grant)      w_state_nxt = S_GAP;
      end
      S_GAP: begin
        w_state_nxt = bus.cfg_pause_req ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!bus.cfg_pause_req) w_state_nxt = S_IDLE;
        else if (w_drained)     w_state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        if (!bus.cfg_pause_req) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk_dp) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr <= PTR_W'((32'(w_grant_idx) + 32'd1) % 32'(NUM_REQ));
      end
    end
  end

  // Issue stage: one-cycle strobe with the granted word, zero otherwise.
  always_ff @(posedge clk_dp) begin
    if (!rst) begin
      r_calc_in_valid <= 1'b0;
      r_calc_in_data  <= '0;
      r_issue_idx     <= '0;
    end else begin
      r_calc_in_valid <= w_grant;
      r_calc_in_data  <= w_grant ?
                         bus.req_data[32'(w_grant_idx)*REQ_DATA_WIDTH +: REQ_DATA_WIDTH] : '0;
      r_issue_idx     <= w_grant_idx;
    end
  end

  // Tag pipeline entered alongside the issue strobe; its output lines up with
  // the calculator result.
  always_ff @(posedge clk_dp) begin
    if (!rst) begin
      r_tag_v <= '0;
      for (int k = 0; k < CALC_LATENCY; k++) begin
        r_tag_idx[k] <= '0;
      end
    end else begin
      r_tag_v[0]   <= r_calc_in_valid;
      r_tag_idx[0] <= r_issue_idx;
      for (int k = 1; k < CALC_LATENCY; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  // Response return and sticky mismatch flag.
  always_ff @(posedge clk_dp) begin
    if (!rst) begin
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_rsp_valid  <= w_hit ? (NUM_REQ'(1) << w_tag_out_idx) : '0;
      r_rsp_data   <= w_hit ? bus.calc_out_data : '0;
      r_err_sticky <= r_err_sticky | w_mismatch;
    end
  end

  // Saturating count of cycles with pending requests but no grant.
  always_ff @(posedge clk_dp) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.calc_in_valid = r_calc_in_valid;
  assign bus.calc_in_data  = r_calc_in_data;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.cfg_pause_ack = (r_state == S_PAUSED);
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.err_sticky    = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_drr_rank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_drr_rank_arbiter
// Description : Directed self-checking bench for drr_rank_arbiter with a
//               two-cycle echo calculator model that can drop or inject
//               results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drr_rank_arbiter;

  localparam int NR = 4;
  localparam int DW = 24;
  localparam int RW = 32;
  localparam int CL = 2;
  localparam int SW = 16;

  logic clk_dp = 1'b0;
  logic rst;

  always #5 clk_dp = ~clk_dp;

  drr_rank_arbiter_if #(
    .NUM_REQ(NR), .REQ_DATA_WIDTH(DW), .RESULT_WIDTH(RW), .STALL_CNT_WIDTH(SW)
  ) bus ();

  drr_rank_arbiter #(
    .NUM_REQ(NR), .REQ_DATA_WIDTH(DW), .RESULT_WIDTH(RW),
    .CALC_LATENCY(CL), .STALL_CNT_WIDTH(SW)
  ) u_dut (
    .clk_dp (clk_dp),
    .rst    (rst),
    .bus    (bus)
  );

  // Calculator model: result appears two cycles after the issue strobe.
  logic          m_v0, m_v1;
  logic [DW-1:0] m_d0, m_d1;
  logic          drop, inject, use_fixed;

  always @(posedge clk_dp) begin
    if (!rst) begin
      m_v0 <= 1'b0; m_v1 <= 1'b0; m_d0 <= '0; m_d1 <= '0;
    end else begin
      m_v0 <= bus.calc_in_valid; m_d0 <= bus.calc_in_data;
      m_v1 <= m_v0;              m_d1 <= m_d0;
    end
  end

  assign bus.calc_out_valid = (m_v1 & ~drop) | inject;
  assign bus.calc_out_data  = use_fixed ? 32'h12345678 : {8'hA5, m_d1};

  logic [DW-1:0] dword [NR];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk_dp);
    #1;
  endtask

  initial begin
    dword[0] = 24'h0A0023;
    dword[1] = 24'h111111;
    dword[2] = 24'h222222;
    dword[3] = 24'h333333;

    rst = 1'b0;
    bus.req_valid     = 4'hF;
    bus.req_data      = {dword[3], dword[2], dword[1], dword[0]};
    bus.cfg_pause_req = 1'b0;
    drop = 1'b0; inject = 1'b0; use_fixed = 1'b0;

    // Reset state
    step(); step();
    check_eq("rst_ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst_civ", 32'(bus.calc_in_valid), 32'h0);
    check_eq("rst_cid", 32'(bus.calc_in_data), 32'h0);
    check_eq("rst_rspv", 32'(bus.rsp_valid), 32'h0);
    check_eq("rst_rspd", bus.rsp_data, 32'h0);
    check_eq("rst_ack", 32'(bus.cfg_pause_ack), 32'h0);
    check_eq("rst_stall", 32'(bus.stall_cnt), 32'h0);
    check_eq("rst_err", 32'(bus.err_sticky), 32'h0);
    rst = 1'b1; bus.req_valid = 4'h0;
    step();

    // Single request with fixed calculator result
    bus.req_valid = 4'b0001; use_fixed = 1'b1; #1;
    check_eq("one_ready", 32'(bus.req_ready), 32'h1);
    step(); bus.req_valid = 4'h0; #1;
    check_eq("one_civ", 32'(bus.calc_in_valid), 32'h1);
    check_eq("one_cid", 32'(bus.calc_in_data), 32'h0A0023);
    check_eq("one_gap_ready", 32'(bus.req_ready), 32'h0);
    step();
    check_eq("one_civ_off", 32'(bus.calc_in_valid), 32'h0);
    step();
    check_eq("one_rsp_early", 32'(bus.rsp_valid), 32'h0);
    step();
    check_eq("one_rspv", 32'(bus.rsp_valid), 32'h1);
    check_eq("one_rspd", bus.rsp_data, 32'h12345678);
    step();
    check_eq("one_rsp_off", 32'(bus.rsp_valid), 32'h0);
    check_eq("one_err", 32'(bus.err_sticky), 32'h0);
    check_eq("one_stall", 32'(bus.stall_cnt), 32'h0);
    use_fixed = 1'b0;

    // Reset one cycle after a grant (pointer sits at 1 here)
    bus.req_valid = 4'hF; #1;
    check_eq("mid_ready", 32'(bus.req_ready), 32'h2);
    step(); rst = 1'b0; #1;
    check_eq("mid_ready_rst", 32'(bus.req_ready), 32'h0);
    step();
    check_eq("mid_civ", 32'(bus.calc_in_valid), 32'h0);
    check_eq("mid_rspv", 32'(bus.rsp_valid), 32'h0);
    check_eq("mid_stall", 32'(bus.stall_cnt), 32'h0);
    check_eq("mid_err", 32'(bus.err_sticky), 32'h0);
    rst = 1'b1; #1;

    // All four requesting: grants 0,1,2,3,0 every other cycle
    for (int g = 0; g < 7; g++) begin
      if (g <= 4) check_eq("rr_ready", 32'(bus.req_ready), 32'h1 << (g % 4));
      else        check_eq("rr_ready_idle", 32'(bus.req_ready), 32'h0);
      check_eq("rr_civ_even", 32'(bus.calc_in_valid), 32'h0);
      if (g >= 2) begin
        check_eq("rr_rspv", 32'(bus.rsp_valid), 32'h1 << ((g - 2) % 4));
        check_eq("rr_rspd", bus.rsp_data, {8'hA5, dword[(g - 2) % 4]});
      end
      if (g <= 4) check_eq("rr_stall", 32'(bus.stall_cnt), 32'(g));
      step();
      check_eq("rr_gap_ready", 32'(bus.req_ready), 32'h0);
      if (g <= 4) begin
        check_eq("rr_civ", 32'(bus.calc_in_valid), 32'h1);
        check_eq("rr_cid", 32'(bus.calc_in_data), 32'(dword[g % 4]));
      end else begin
        check_eq("rr_civ_idle", 32'(bus.calc_in_valid), 32'h0);
      end
      check_eq("rr_rsp_odd", 32'(bus.rsp_valid), 32'h0);
      if (g == 4) bus.req_valid = 4'h0;
      step();
    end
    check_eq("rr_stall_end", 32'(bus.stall_cnt), 32'h4);
    check_eq("rr_err", 32'(bus.err_sticky), 32'h0);

    // Pause with one request in flight (pointer at 1)
    bus.req_valid = 4'b0010; #1;
    check_eq("pz_ready", 32'(bus.req_ready), 32'h2);
    step(); bus.req_valid = 4'h0; bus.cfg_pause_req = 1'b1; #1;
    check_eq("pz_civ", 32'(bus.calc_in_valid), 32'h1);
    step(); bus.req_valid = 4'hF; #1;
    check_eq("pz_drain_ready", 32'(bus.req_ready), 32'h0);
    check_eq("pz_drain_ack", 32'(bus.cfg_pause_ack), 32'h0);
    step();
    check_eq("pz_drain_ready2", 32'(bus.req_ready), 32'h0);
    check_eq("pz_drain_ack2", 32'(bus.cfg_pause_ack), 32'h0);
    step();
    check_eq("pz_drain_ack3", 32'(bus.cfg_pause_ack), 32'h0);
    check_eq("pz_rspv", 32'(bus.rsp_valid), 32'h2);
    check_eq("pz_rspd", bus.rsp_data, {8'hA5, dword[1]});
    step();
    check_eq("pz_ack", 32'(bus.cfg_pause_ack), 32'h1);
    check_eq("pz_ack_ready", 32'(bus.req_ready), 32'h0);
    step();
    check_eq("pz_ack2", 32'(bus.cfg_pause_ack), 32'h1);
    check_eq("pz_ack_ready2", 32'(bus.req_ready), 32'h0);
    bus.cfg_pause_req = 1'b0;
    step();
    check_eq("pz_resume_ready", 32'(bus.req_ready), 32'h4);
    check_eq("pz_resume_ack", 32'(bus.cfg_pause_ack), 32'h0);
    check_eq("pz_stall", 32'(bus.stall_cnt), 32'h9);
    step(); bus.req_valid = 4'h0; #1;
    check_eq("pz_resume_cid", 32'(bus.calc_in_data), 32'(dword[2]));
    step(); step(); step();
    check_eq("pz_resume_rspv", 32'(bus.rsp_valid), 32'h4);
    check_eq("pz_resume_rspd", bus.rsp_data, {8'hA5, dword[2]});

    // Dropped calculator result
    rst = 1'b0; step(); rst = 1'b1; #1;
    check_eq("drop_err_clr", 32'(bus.err_sticky), 32'h0);
    bus.req_valid = 4'b0001; #1;
    check_eq("drop_ready", 32'(bus.req_ready), 32'h1);
    step(); bus.req_valid = 4'h0;
    step(); step(); drop = 1'b1;
    step(); drop = 1'b0; #1;
    check_eq("drop_rspv", 32'(bus.rsp_valid), 32'h0);
    check_eq("drop_err", 32'(bus.err_sticky), 32'h1);
    step();
    check_eq("drop_err_hold", 32'(bus.err_sticky), 32'h1);

    // Injected result with no tag in flight
    rst = 1'b0; step(); rst = 1'b1; #1;
    check_eq("inj_err_clr", 32'(bus.err_sticky), 32'h0);
    step(); inject = 1'b1;
    step(); inject = 1'b0; #1;
    check_eq("inj_err", 32'(bus.err_sticky), 32'h1);
    check_eq("inj_rspv", 32'(bus.rsp_valid), 32'h0);
    step();
    check_eq("inj_err_hold", 32'(bus.err_sticky), 32'h1);
    check_eq("inj_rspv2", 32'(bus.rsp_valid), 32'h0);

    // Stall counter saturation while paused with a pending request
    rst = 1'b0; step();
    rst = 1'b1; bus.req_valid = 4'b0001; bus.cfg_pause_req = 1'b1; #1;
    check_eq("sat_no_grant", 32'(bus.req_ready), 32'h0);
    check_eq("sat_start", 32'(bus.stall_cnt), 32'h0);
    repeat (65534) step();
    check_eq("sat_fffe", 32'(bus.stall_cnt), 32'hFFFE);
    step();
    check_eq("sat_ffff", 32'(bus.stall_cnt), 32'hFFFF);
    repeat (4465) step();
    check_eq("sat_hold", 32'(bus.stall_cnt), 32'hFFFF);
    check_eq("sat_ack", 32'(bus.cfg_pause_ack), 32'h1);
    check_eq("sat_ready", 32'(bus.req_ready), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/drr_rank_arbiter.md
DRR_RANK_ARBITER -- requirements
Module: drr_rank_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, default 4: number of requesters.
- REQ_DATA_WIDTH, default 24: request word {pkt_size[10:0], port[7:0], class[4:0]}.
- RESULT_WIDTH, default 32: rank word width.
- CALC_LATENCY, default 2: calculator cycles from input valid to output valid.
- STALL_CNT_WIDTH, default 16: stall counter width.

REQ-002 Ports SHALL be:
- clk_dp in 1: clock; all logic rising-edge on clk_dp.
- rst in 1: reset, synchronous, active-low.
- req_valid in NUM_REQ: per-requester request valid.
- req_data in NUM_REQ*REQ_DATA_WIDTH: requester i occupies bits [i*REQ_DATA_WIDTH +: REQ_DATA_WIDTH].
- req_ready out NUM_REQ: one-hot grant/accept.
- calc_in_valid out 1: issue strobe to the rank calculator.
- calc_in_data out REQ_DATA_WIDTH: issued request word.
- calc_out_valid in 1: calculator result valid.
- calc_out_data in RESULT_WIDTH: calculator result.
- rsp_valid out NUM_REQ: one-hot result return.
- rsp_data out RESULT_WIDTH: returned rank.
- cfg_pause_req in 1: control plane requests quiescence for a weight write.
- cfg_pause_ack out 1: calculator idle, safe to reconfigure.
- stall_cnt out STALL_CNT_WIDTH: cycles with pending requests but no grant.
- err_sticky out 1: response/tag mismatch seen.

Function
REQ-003 Handshake SHALL be: transfer when req_valid[i] and req_ready[i] are both high; req_ready is combinational from req_valid and state; at most one bit is high per cycle.
REQ-004 FSM states SHALL be IDLE, GAP, DRAIN and PAUSED.
REQ-005 Grants SHALL occur only in IDLE with cfg_pause_req low.
REQ-006 Arbitration SHALL be round-robin: search from ptr upward with modulo NUM_REQ; grant the first valid requester; then ptr <= grant+1 mod NUM_REQ; ptr is unchanged when there is no grant.
REQ-007 A grant in cycle t SHALL drive calc_in_valid=1 and calc_in_data=granted word, both registered, in cycle t+1 only.
REQ-008 After every grant the FSM SHALL enter GAP for exactly one cycle, so that issues are at least 2 cycles apart (calculator cannot take back-to-back inputs).
REQ-009 From GAP the FSM SHALL go to DRAIN if cfg_pause_req=1, else to IDLE.
REQ-010 An issued request SHALL push a tag {1, grant index} into a CALC_LATENCY-deep shift pipeline aligned with calc_in_valid; an empty slot SHALL carry tag valid 0.
REQ-011 When the tag leaving the pipeline is valid and calc_out_valid=1, the block SHALL drive rsp_valid=onehot(index) and rsp_data=calc_out_data one cycle later, for one cycle; otherwise rsp_valid=0 and rsp_data=0.
REQ-012 End-to-end latency SHALL be: accept at t, calc_in_valid at t+1, calc_out_valid expected at t+1+CALC_LATENCY, rsp_valid at t+2+CALC_LATENCY.
REQ-013 A tag/valid mismatch (valid tag without calc_out_valid, or calc_out_valid without valid tag) SHALL set err_sticky=1 and produce no rsp_valid; err_sticky clears only on reset.
REQ-014 IDLE with cfg_pause_req=1 SHALL go to DRAIN and issue no grant that cycle.
REQ-015 DRAIN SHALL go to PAUSED once calc_in_valid=0 and all tag slots are invalid.
REQ-016 In PAUSED, cfg_pause_ack SHALL be 1; cfg_pause_ack SHALL be 0 in all other states.
REQ-017 PAUSED with cfg_pause_req=0 SHALL go to IDLE, and grants resume the following cycle.
REQ-018 cfg_pause_req deasserted during DRAIN SHALL return the FSM to IDLE without passing through PAUSED.
REQ-019 stall_cnt SHALL increment in each cycle where |req_valid=1 and no grant occurs, and SHALL saturate at all-ones.

Reset
REQ-020 With rst=0 at a clk_dp edge, the block SHALL reset: state=IDLE, ptr=0, tag pipeline invalid, calc_in_valid=0, calc_in_data=0, rsp_valid=0, rsp_data=0, cfg_pause_ack=0, stall_cnt=0, err_sticky=0.
REQ-021 req_ready SHALL be 0 while rst=0.
REQ-022 Reset mid-operation SHALL discard in-flight tags; a calc_out_valid arriving after reset release with no tag SHALL set err_sticky.

Verification
REQ-023 Single request: req_valid=0001, data 0x050_01_03, calculator echoes 0x12345678 -> req_ready=0001 at t, calc_in_valid at t+1, rsp_valid=0001 with rsp_data=0x12345678 at t+4.
REQ-024 All four requesting continuously -> grants 0,1,2,3,0 on cycles t, t+2, t+4, t+6, t+8; no two calc_in_valid pulses adjacent; stall_cnt increments in every GAP cycle.
REQ-025 Pause with one request in flight -> FSM passes through DRAIN, cfg_pause_ack=1 two cycles after the last calc_out_valid, no grants while acked; deassert -> grant on the next IDLE cycle.
REQ-026 Inject calc_out_valid with empty tag pipeline -> err_sticky=1, rsp_valid stays 0; drop an expected calc_out_valid -> err_sticky=1, no response for that tag.
REQ-027 rst=0 one cycle after a grant -> all outputs 0 next cycle, ptr=0; after release the first grant goes to requester 0 when all are valid.
REQ-028 Hold req_valid=0001 with cfg_pause_req=1 for 70000 cycles -> stall_cnt saturates at 0xFFFF.
